// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Brief    : Four-state SRAM access sequencer (IDLE/SETUP/ACCESS/DONE) with a
//            programmable strobe length; optional I/O map of address 0xFFFF
//            to switches / hex display, enabled by macro MEM_IO_MAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        WE,
    input  logic [15:0] ADDR,
    input  logic [15:0] WDATA,
    output logic [15:0] RDATA,
    output logic        Ready,
    output logic        Busy,
    output logic [19:0] SRAM_ADDR,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N,
    output logic [15:0] SRAM_DQ_OUT,
    output logic        SRAM_DQ_OE,
    input  logic [15:0] SRAM_DQ_IN,
    input  logic [15:0] SW,
    output logic [15:0] HEX_DATA
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] c_CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic        r_we;
    logic        r_io;
    logic [3:0]  r_cnt;
    logic [15:0] r_rdata;
    logic        w_is_io;
    logic        w_last;

`ifdef MEM_IO_MAP_EN
    assign w_is_io = (ADDR == 16'hFFFF);
`else
    assign w_is_io = 1'b0;
`endif

    assign w_last = (r_state == S_ACCESS) && (r_cnt == 4'd0);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_addr  <= 16'h0;
            r_wdata <= 16'h0;
            r_we    <= 1'b0;
            r_io    <= 1'b0;
            r_cnt   <= 4'd0;
            r_rdata <= 16'h0;
        end else begin
            // Transaction fields are frozen at acceptance; later ADDR/WDATA are ignored
            if (r_state == S_IDLE && Req) begin
                r_addr  <= ADDR;
                r_wdata <= WDATA;
                r_we    <= WE;
                r_io    <= w_is_io;
            end
            if (r_state == S_SETUP) begin
                r_cnt <= c_CNT_LOAD;
            end else if (r_state == S_ACCESS && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_last && !r_we) begin
                r_rdata <= r_io ? SW : SRAM_DQ_IN;
            end
        end
    end

`ifdef MEM_IO_MAP_EN
    logic [15:0] r_hex;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_hex <= 16'h0;
        end else if (r_state == S_DONE && r_we && r_io) begin
            r_hex <= r_wdata;
        end
    end

    assign HEX_DATA = r_hex;
`else
    logic w_unused_sw;

    assign w_unused_sw = ^SW;
    assign HEX_DATA    = 16'h0;
`endif

    // Strobes decode from state so an asynchronous reset releases them at once
    always_comb begin
        w_next     = r_state;
        SRAM_CE_N  = 1'b1;
        SRAM_OE_N  = 1'b1;
        SRAM_WE_N  = 1'b1;
        SRAM_DQ_OE = 1'b0;
        Ready      = 1'b0;
        Busy       = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (Req) begin
                    w_next = S_SETUP;
                end
            end
            S_SETUP: begin
                SRAM_CE_N  = r_io;
                SRAM_DQ_OE = r_we & ~r_io;
                w_next     = S_ACCESS;
            end
            S_ACCESS: begin
                SRAM_CE_N  = r_io;
                SRAM_OE_N  = r_we | r_io;
                SRAM_WE_N  = ~r_we | r_io;
                SRAM_DQ_OE = r_we & ~r_io;
                if (r_cnt == 4'd0) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                SRAM_DQ_OE = r_we & ~r_io;
                Ready      = 1'b1;
                w_next     = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign SRAM_ADDR   = {4'h0, r_addr};
    assign SRAM_DQ_OUT = r_wdata;
    assign RDATA       = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_ctrl
// Brief    : Directed self-checking bench for mem_access_ctrl (WAIT_CYCLES=2
//            and WAIT_CYCLES=1 instances); honours MEM_IO_MAP_EN if defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Req, Req1, WE;
    logic [15:0] ADDR, WDATA, SRAM_DQ_IN, SW;

    logic [15:0] RDATA, SRAM_DQ_OUT, HEX_DATA;
    logic        Ready, Busy, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_DQ_OE;
    logic [19:0] SRAM_ADDR;

    logic [15:0] RDATA_1, SRAM_DQ_OUT_1, HEX_DATA_1;
    logic        Ready_1, Busy_1, SRAM_CE_N_1, SRAM_OE_N_1, SRAM_WE_N_1, SRAM_DQ_OE_1;
    logic [19:0] SRAM_ADDR_1;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    mem_access_ctrl #(.WAIT_CYCLES(2)) dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .WE(WE), .ADDR(ADDR), .WDATA(WDATA),
        .RDATA(RDATA), .Ready(Ready), .Busy(Busy), .SRAM_ADDR(SRAM_ADDR),
        .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N),
        .SRAM_DQ_OUT(SRAM_DQ_OUT), .SRAM_DQ_OE(SRAM_DQ_OE), .SRAM_DQ_IN(SRAM_DQ_IN),
        .SW(SW), .HEX_DATA(HEX_DATA)
    );

    mem_access_ctrl #(.WAIT_CYCLES(1)) dut1 (
        .Clk(Clk), .Reset(Reset), .Req(Req1), .WE(WE), .ADDR(ADDR), .WDATA(WDATA),
        .RDATA(RDATA_1), .Ready(Ready_1), .Busy(Busy_1), .SRAM_ADDR(SRAM_ADDR_1),
        .SRAM_CE_N(SRAM_CE_N_1), .SRAM_OE_N(SRAM_OE_N_1), .SRAM_WE_N(SRAM_WE_N_1),
        .SRAM_DQ_OUT(SRAM_DQ_OUT_1), .SRAM_DQ_OE(SRAM_DQ_OE_1), .SRAM_DQ_IN(SRAM_DQ_IN),
        .SW(SW), .HEX_DATA(HEX_DATA_1)
    );

    typedef struct {
        logic        req;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] dqin;
        logic        busy;
        logic        ready;
        logic [3:0]  str;     // {CE_N, OE_N, WE_N, DQ_OE}
        logic [19:0] saddr;
        logic [15:0] dqout;
        logic [15:0] rdata;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Start of a cycle: just after the rising edge
    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        int n;

        // write 0x1234 @0x0040, read @0x0040 (DQ_IN valid only on last ACCESS), write @0x0041
        tbl[0]  = '{1'b1, 1'b1, 16'h0040, 16'h1234, 16'hBEEF, 1'b0, 1'b0, 4'b1110, 20'h00000, 16'h0000, 16'h0000};
        tbl[1]  = '{1'b0, 1'b0, 16'h1111, 16'h9999, 16'hBEEF, 1'b1, 1'b0, 4'b0111, 20'h00040, 16'h1234, 16'h0000};
        tbl[2]  = '{1'b1, 1'b0, 16'h1111, 16'h9999, 16'hBEEF, 1'b1, 1'b0, 4'b0101, 20'h00040, 16'h1234, 16'h0000};
        tbl[3]  = '{1'b0, 1'b0, 16'h1111, 16'h9999, 16'hBEEF, 1'b1, 1'b0, 4'b0101, 20'h00040, 16'h1234, 16'h0000};
        tbl[4]  = '{1'b1, 1'b0, 16'h2222, 16'h9999, 16'hBEEF, 1'b1, 1'b1, 4'b1111, 20'h00040, 16'h1234, 16'h0000};
        tbl[5]  = '{1'b1, 1'b0, 16'h0040, 16'h7777, 16'hBEEF, 1'b0, 1'b0, 4'b1110, 20'h00040, 16'h1234, 16'h0000};
        tbl[6]  = '{1'b0, 1'b1, 16'h2222, 16'h8888, 16'hBEEF, 1'b1, 1'b0, 4'b0110, 20'h00040, 16'h7777, 16'h0000};
        tbl[7]  = '{1'b0, 1'b1, 16'h2222, 16'h8888, 16'hDEAD, 1'b1, 1'b0, 4'b0010, 20'h00040, 16'h7777, 16'h0000};
        tbl[8]  = '{1'b0, 1'b1, 16'h2222, 16'h8888, 16'hBEEF, 1'b1, 1'b0, 4'b0010, 20'h00040, 16'h7777, 16'h0000};
        tbl[9]  = '{1'b0, 1'b0, 16'h2222, 16'h8888, 16'h0000, 1'b1, 1'b1, 4'b1110, 20'h00040, 16'h7777, 16'hBEEF};
        tbl[10] = '{1'b1, 1'b1, 16'h0041, 16'h5555, 16'h0000, 1'b0, 1'b0, 4'b1110, 20'h00040, 16'h7777, 16'hBEEF};
        tbl[11] = '{1'b0, 1'b0, 16'h3333, 16'h0000, 16'h0000, 1'b1, 1'b0, 4'b0111, 20'h00041, 16'h5555, 16'hBEEF};
        tbl[12] = '{1'b0, 1'b0, 16'h3333, 16'h0000, 16'h0000, 1'b1, 1'b0, 4'b0101, 20'h00041, 16'h5555, 16'hBEEF};
        tbl[13] = '{1'b0, 1'b0, 16'h3333, 16'h0000, 16'h0000, 1'b1, 1'b0, 4'b0101, 20'h00041, 16'h5555, 16'hBEEF};
        tbl[14] = '{1'b0, 1'b0, 16'h3333, 16'h0000, 16'h0000, 1'b1, 1'b1, 4'b1111, 20'h00041, 16'h5555, 16'hBEEF};
        tbl[15] = '{1'b0, 1'b0, 16'h3333, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'b1110, 20'h00041, 16'h5555, 16'hBEEF};

        Reset = 1'b1; Req = 1'b0; Req1 = 1'b0; WE = 1'b0;
        ADDR = 16'h0; WDATA = 16'h0; SRAM_DQ_IN = 16'h0; SW = 16'h00A5;

        // ---- reset state ----
        #12;
        chk("rst_busy_ready", {Busy, Ready}, 2'b00);
        chk("rst_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_DQ_OE}, 4'b1110);
        chk("rst_rdata_hex", {RDATA, HEX_DATA}, 32'h0);
        chk("rst_addr_dq", {12'h0, SRAM_ADDR}, {12'h0, 20'h0});
        chk("rst_dqout", SRAM_DQ_OUT, 16'h0);
        chk("rst_dut1_strobes", {Busy_1, SRAM_CE_N_1, SRAM_OE_N_1, SRAM_WE_N_1, SRAM_DQ_OE_1}, 5'b01110);
        @(negedge Clk);
        Reset = 1'b0;

        // ---- table-driven write / read / write ----
        for (int i = 0; i < 16; i++) begin
            cyc();
            Req = tbl[i].req; WE = tbl[i].we; ADDR = tbl[i].addr;
            WDATA = tbl[i].wdata; SRAM_DQ_IN = tbl[i].dqin;
            @(negedge Clk);
            chk($sformatf("tbl%0d_busy_ready", i), {Busy, Ready}, {tbl[i].busy, tbl[i].ready});
            chk($sformatf("tbl%0d_strobes", i), {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_DQ_OE}, tbl[i].str);
            chk($sformatf("tbl%0d_sram_addr", i), SRAM_ADDR, tbl[i].saddr);
            chk($sformatf("tbl%0d_dq_out", i), SRAM_DQ_OUT, tbl[i].dqout);
            chk($sformatf("tbl%0d_rdata", i), RDATA, tbl[i].rdata);
        end

        // ---- Req held high, ADDR stepping: accepts in cycles 0, 5, 10 ----
        for (int c = 0; c <= 10; c++) begin
            cyc();
            Req = 1'b1; WE = 1'b0; ADDR = 16'h0100 + 16'(c);
            @(negedge Clk);
            chk($sformatf("hold_busy_c%0d", c), Busy, (c % 5) != 0);
            if (c == 1) chk("hold_addr_c1", SRAM_ADDR, 20'h00100);
            if (c == 6) chk("hold_addr_c6", SRAM_ADDR, 20'h00105);
        end
        Req = 1'b0;
        for (n = 0; n < 10; n++) begin
            cyc();
            @(negedge Clk);
            if (!Busy) break;
        end
        chk("hold_drain_idle", Busy, 1'b0);

        // ---- asynchronous reset in cycle 2 of a write ----
        cyc(); Req = 1'b1; WE = 1'b1; ADDR = 16'h0050; WDATA = 16'hAAAA;
        cyc(); Req = 1'b0;
        cyc();
        chk("rstmid_we_low", SRAM_WE_N, 1'b0);
        #1 Reset = 1'b1;
        #1;
        chk("rstmid_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_DQ_OE}, 4'b1110);
        chk("rstmid_busy_ready", {Busy, Ready}, 2'b00);
        #1 Reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            cyc();
            @(negedge Clk);
            chk($sformatf("rstmid_quiet%0d", c), {Busy, Ready}, 2'b00);
        end
        cyc(); Req = 1'b1; WE = 1'b0; ADDR = 16'h0050; SRAM_DQ_IN = 16'h1357;
        for (n = 1; n <= 10; n++) begin
            cyc(); Req = 1'b0;
            @(negedge Clk);
            if (Ready) break;
        end
        chk("rstmid_next_latency", n, 4);
        chk("rstmid_next_rdata", RDATA, 16'h1357);

        // ---- WAIT_CYCLES=1 instance ----
        cyc(); Req1 = 1'b1; WE = 1'b0; ADDR = 16'h0060;
        for (int c = 1; c <= 4; c++) begin
            cyc(); Req1 = 1'b0;
            @(negedge Clk);
            chk($sformatf("w1_oe_n_c%0d", c), SRAM_OE_N_1, c != 2);
            chk($sformatf("w1_ready_c%0d", c), Ready_1, c == 3);
        end

        // ---- address 0xFFFF ----
`ifdef MEM_IO_MAP_EN
        cyc(); Req = 1'b1; WE = 1'b0; ADDR = 16'hFFFF; SRAM_DQ_IN = 16'h4444;
        for (int c = 1; c <= 4; c++) begin
            cyc(); Req = 1'b0;
            @(negedge Clk);
            chk($sformatf("io_rd_strobes_c%0d", c), {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_DQ_OE}, 4'b1110);
        end
        chk("io_rd_rdata", RDATA, 16'h00A5);
        cyc(); Req = 1'b1; WE = 1'b1; ADDR = 16'hFFFF; WDATA = 16'h0C0D;
        for (int c = 1; c <= 5; c++) begin
            cyc(); Req = 1'b0;
            @(negedge Clk);
            if (c <= 4) chk($sformatf("io_wr_strobes_c%0d", c), {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_DQ_OE}, 4'b1110);
            if (c == 4) chk("io_wr_hex_c4", HEX_DATA, 16'h0000);
            if (c == 5) chk("io_wr_hex_c5", HEX_DATA, 16'h0C0D);
        end
`else
        cyc(); Req = 1'b1; WE = 1'b1; ADDR = 16'hFFFF; WDATA = 16'h0C0D;
        for (int c = 1; c <= 5; c++) begin
            cyc(); Req = 1'b0;
            @(negedge Clk);
            if (c == 1) chk("ffff_sram_addr", SRAM_ADDR, 20'h0FFFF);
            if (c == 2) chk("ffff_we_ce", {SRAM_CE_N, SRAM_WE_N, SRAM_DQ_OE}, 3'b001);
            if (c == 5) chk("ffff_hex_zero", HEX_DATA, 16'h0000);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, number of SRAM strobe cycles per access (legal 1..15).
REQ-002 SHALL have a single clock and an asynchronous, active-high reset: Clk  in  1  rising-edge clock; Reset  in  1  async active-high reset.
REQ-003 Req  in  1  access request, sampled in IDLE only.
REQ-004 WE  in  1  1=write, 0=read; sampled with Req.
REQ-005 ADDR  in  16  word address, from the MAR output.
REQ-006 WDATA  in  16  write data, from the MDR output.
REQ-007 RDATA  out  16  registered read data, feeds the MDR memory-side load input.
REQ-008 Ready  out  1  one-cycle completion pulse; Busy  out  1  high whenever state is not IDLE.
REQ-009 SRAM_ADDR  out  20; SRAM_CE_N, SRAM_OE_N, SRAM_WE_N  out  1 each, active-low strobes.
REQ-010 SRAM_DQ_OUT  out  16; SRAM_DQ_OE  out  1  tristate enable; SRAM_DQ_IN  in  16.
REQ-011 SW  in  16  switch inputs; HEX_DATA  out  16  registered display value.

Function
REQ-012 FSM states SHALL be IDLE, SETUP, ACCESS and DONE.
REQ-013 IDLE: on Req=1, latch ADDR, WDATA and WE, then go to SETUP; otherwise stay in IDLE.
REQ-014 SETUP (1 cycle): SRAM_ADDR={4'h0,addr}, CE_N=0, DQ_OE=1 if write; load wait counter with WAIT_CYCLES-1; go to ACCESS.
REQ-015 ACCESS: CE_N=0; read drives OE_N=0, write drives WE_N=0 with DQ_OE=1 and DQ_OUT=latched data; counter decrements each cycle; when counter=0, go to DONE.
REQ-016 Read data SHALL be captured from SRAM_DQ_IN into RDATA on the last ACCESS cycle.
REQ-017 DONE (1 cycle): all strobes high; DQ_OE held on writes for data hold; Ready=1; go to IDLE.
REQ-018 Latency: Req accepted in cycle T gives Ready in cycle T+WAIT_CYCLES+2.
REQ-019 Req SHALL be ignored in SETUP, ACCESS and DONE; a Req in the cycle after DONE is accepted, so back-to-back throughput is one access per WAIT_CYCLES+3 cycles.
REQ-020 RDATA SHALL hold its value until the next read completes; writes never change RDATA.
REQ-021 OE_N and WE_N SHALL never be low together; DQ_OE SHALL never be 1 during a read.
REQ-022 ADDR/WDATA changes after acceptance SHALL NOT affect the transaction in flight.

Reset
REQ-023 Reset=1 SHALL immediately (asynchronously) force IDLE; CE_N=OE_N=WE_N=1; DQ_OE=0; Ready=0; Busy=0; RDATA=0; HEX_DATA=0; SRAM_ADDR=0; SRAM_DQ_OUT=0; counter=0.
REQ-024 Reset during any non-IDLE state SHALL drop the transaction: no Ready, no RDATA or HEX_DATA update, and strobes deasserted in the same cycle.

Configuration
REQ-025 Macro MEM_IO_MAP_EN, when defined, SHALL map address 0xFFFF to I/O:
  - reads return SW, sampled on the last ACCESS cycle;
  - writes load HEX_DATA on the DONE cycle;
  - CE_N, OE_N and WE_N stay high and DQ_OE stays 0 for that access;
  - FSM timing is identical to an SRAM access.
REQ-026 Without MEM_IO_MAP_EN, 0xFFFF SHALL be an ordinary SRAM access at 0x0FFFF, HEX_DATA SHALL be constant 0, and SW SHALL be unused.

Verification (WAIT_CYCLES=2, Req in cycle 0 unless stated)
REQ-027 Write 0x1234 to 0x0040 -> SRAM_ADDR=0x00040 from cycle 1; WE_N low cycles 2-3; DQ_OUT=0x1234 with DQ_OE=1 cycles 1-4; Ready=1 in cycle 4 only.
REQ-028 Read 0x0040 with DQ_IN=0xBEEF -> OE_N low cycles 2-3; RDATA=0xBEEF from cycle 4; Ready=1 in cycle 4; WE_N stays 1.
REQ-029 MEM_IO_MAP_EN defined, SW=0x00A5:
  - read 0xFFFF -> RDATA=0x00A5 and CE_N stays 1;
  - write 0x0C0D to 0xFFFF -> HEX_DATA=0x0C0D after cycle 4;
  - same write without the macro -> SRAM write at 0x0FFFF and HEX_DATA=0.
REQ-030 Req held high with ADDR stepping each cycle -> accepts only in cycles 0, 5 and 10; Busy low only in those cycles.
REQ-031 Reset pulsed in cycle 2 of a write -> WE_N=1 and DQ_OE=0 within the same cycle; no Ready; Busy=0; next Req completes normally.
REQ-032 WAIT_CYCLES=1, read -> OE_N low in cycle 2 only; Ready in cycle 3.
